l2_cache_assoc: RTL and testbench

//   Parametrised set-associative, write-back L2 cache between the CPU-side burst port and the UMA memory bus.

---
 rtl/l2_cache_pkg.sv | 34 +++
 rtl/l2_cache_way.sv | 64 ++++++
 rtl/l2_cache_assoc.sv | 262 ++++++++++++++++++++++++++
 tb/tb_l2_cache_assoc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types, default geometry and address field helpers for the set-associative L2 cache.
// The optional hit/miss counters are enabled with the L2_CACHE_STATS_EN macro (see l2_cache_assoc).
`timescale 1ns/1ps
package l2_cache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, XFER} state_t;

  localparam int DEF_SETS       = 32;
  localparam int DEF_WAYS       = 2;
  localparam int DEF_LINE_WORDS = 16;

  localparam int SET_W  = $clog2(DEF_SETS);
  localparam int WORD_W = $clog2(DEF_LINE_WORDS);
  localparam int TAG_W  = 30 - SET_W - WORD_W;

  function automatic int tag_bits(input int sets, input int line_words);
    return 30 - $clog2(sets) - $clog2(line_words);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a, input int word_bits);
    return (a >> 2) & ((32'd1 << word_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] set_of(input logic [31:0] a, input int set_bits,
                                         input int word_bits);
    return (a >> (2 + word_bits)) & ((32'd1 << set_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a, input int set_bits,
                                         input int word_bits);
    return a >> (2 + set_bits + word_bits);
  endfunction

endpackage

// File: rtl/l2_cache_way.sv
// One way of the L2: tag/valid/dirty per set plus the line data array.
// Hit and read word are combinational on the shared (set, word) index.
`timescale 1ns/1ps
module l2_cache_way
  import l2_cache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int SET_BITS   = $clog2(SETS),
  parameter int WORD_BITS  = $clog2(LINE_WORDS),
  parameter int TAG_BITS   = tag_bits(SETS, LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SET_BITS-1:0]  set_idx,
  input  logic [WORD_BITS-1:0] word_idx,
  input  logic [TAG_BITS-1:0]  cmp_tag,
  input  logic                 wr_word_en,
  input  logic                 fill_en,
  input  logic                 install_en,
  input  logic [31:0]          wr_data,
  output logic                 hit,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  output logic [31:0]          rd_word
);

  logic [31:0]          data_mem [SETS*LINE_WORDS];
  logic [TAG_BITS-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]      valid_reg;
  logic [SETS-1:0]      dirty_reg;
  logic [SET_BITS+WORD_BITS-1:0] word_addr;

  assign word_addr = {set_idx, word_idx};

  always_ff @(posedge clk) begin
    if (wr_word_en || fill_en) data_mem[word_addr] <= wr_data;
  end

  // Tag is installed together with the last fill beat; cmp_tag carries the request tag.
  always_ff @(posedge clk) begin
    if (install_en) tag_mem[set_idx] <= cmp_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (install_en) begin
      valid_reg[set_idx] <= 1'b1;
      dirty_reg[set_idx] <= 1'b0;
    end else if (wr_word_en) begin
      dirty_reg[set_idx] <= 1'b1;
    end
  end

  assign valid   = valid_reg[set_idx];
  assign dirty   = dirty_reg[set_idx];
  assign tag     = tag_mem[set_idx];
  assign hit     = valid && (tag == cmp_tag);
  assign rd_word = data_mem[word_addr];

endmodule

// File: rtl/l2_cache_assoc.sv
// Set-associative write-back L2 with true-LRU replacement, dirty writeback and line fill.
// Define L2_CACHE_STATS_EN to add saturating stat_hit/stat_miss counters.
`timescale 1ns/1ps
module l2_cache_assoc
  import l2_cache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rreq,
  input  logic        wreq,
  input  logic [31:0] addr,
  input  logic [4:0]  burst_size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        bus_rreq,
  output logic        bus_wreq,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_acc,
`ifdef L2_CACHE_STATS_EN
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss,
`endif
  input  logic        bus_busy
);

  localparam int SET_BITS  = $clog2(SETS);
  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS  = tag_bits(SETS, LINE_WORDS);
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t               state_reg, state_next;
  logic [TAG_BITS-1:0]  tag_reg;
  logic [SET_BITS-1:0]  set_reg;
  logic [WORD_BITS-1:0] word_reg;
  logic [WORD_BITS-1:0] beat_reg;
  logic [WAY_BITS-1:0]  way_reg;
  logic [4:0]           left_reg;
  logic                 write_reg;

  logic [WAYS-1:0]      hit_vec, valid_vec, dirty_vec;
  logic [TAG_BITS-1:0]  tag_arr [WAYS];
  logic [31:0]          rd_arr  [WAYS];

  logic                 hit_any, inv_any;
  logic [WAY_BITS-1:0]  hit_idx, inv_idx, lru_idx, victim_idx;
  logic [WORD_BITS-1:0] cur_word;
  logic [31:0]          way_wdata;
  logic                 fill_en, install_en, wr_word_en, beat_fire, lru_touch;

  assign beat_fire = bus_acc && !bus_busy;
  assign lru_touch = (state_reg == XFER) && (left_reg == 5'd1);
  assign way_wdata = (state_reg == FILL) ? bus_rdata : wdata;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      l2_cache_way #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .SET_BITS   (SET_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS)
      ) u_way (
        .clk        (clk),
        .reset      (reset),
        .set_idx    (set_reg),
        .word_idx   (cur_word),
        .cmp_tag    (tag_reg),
        .wr_word_en (wr_word_en && (way_reg == WAY_BITS'(gi))),
        .fill_en    (fill_en    && (way_reg == WAY_BITS'(gi))),
        .install_en (install_en && (way_reg == WAY_BITS'(gi))),
        .wr_data    (way_wdata),
        .hit        (hit_vec[gi]),
        .valid      (valid_vec[gi]),
        .dirty      (dirty_vec[gi]),
        .tag        (tag_arr[gi]),
        .rd_word    (rd_arr[gi])
      );
    end
  endgenerate

  // Downward scan so the lowest-index hit / invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_any = 1'b1;
        hit_idx = WAY_BITS'(w);
      end
      if (!valid_vec[w]) begin
        inv_any = 1'b1;
        inv_idx = WAY_BITS'(w);
      end
    end
  end

  assign victim_idx = inv_any ? inv_idx : lru_idx;

  generate
    if (WAYS > 1) begin : g_lru
      logic [WAY_BITS-1:0] age_reg [SETS][WAYS];
      logic [WAY_BITS-1:0] acc_age;
      logic [WAY_BITS-1:0] best_age;
      logic [WAY_BITS-1:0] lru_pick;

      assign acc_age = age_reg[set_reg][way_reg];

      // Ways no older than the accessed one age by one; ties only exist after reset
      // and are resolved here so the ages become a strict ordering.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age_reg[s][w] <= '0;
        end else if (lru_touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_BITS'(w) == way_reg)
              age_reg[set_reg][w] <= '0;
            else if (age_reg[set_reg][w] <= acc_age && age_reg[set_reg][w] != '1)
              age_reg[set_reg][w] <= age_reg[set_reg][w] + 1'b1;
          end
        end
      end

      always_comb begin
        lru_pick = '0;
        best_age = age_reg[set_reg][0];
        for (int w = 1; w < WAYS; w++) begin
          if (age_reg[set_reg][w] > best_age) begin
            best_age = age_reg[set_reg][w];
            lru_pick = WAY_BITS'(w);
          end
        end
      end

      assign lru_idx = lru_pick;
    end else begin : g_no_lru
      assign lru_idx = '0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    ack        = 1'b0;
    rdata      = '0;
    bus_rreq   = 1'b0;
    bus_wreq   = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    fill_en    = 1'b0;
    install_en = 1'b0;
    wr_word_en = 1'b0;
    cur_word   = word_reg;
    case (state_reg)
      IDLE: begin
        if (rreq || wreq) state_next = LOOKUP;
      end
      LOOKUP: begin
        busy = 1'b1;
        if (hit_any)
          state_next = XFER;
        else if (valid_vec[victim_idx] && dirty_vec[victim_idx])
          state_next = WB;
        else
          state_next = FILL;
      end
      WB: begin
        busy      = 1'b1;
        bus_wreq  = 1'b1;
        cur_word  = beat_reg;
        bus_addr  = {tag_arr[way_reg], set_reg, beat_reg, 2'b00};
        bus_wdata = rd_arr[way_reg];
        if (beat_fire && beat_reg == '1) state_next = FILL;
      end
      FILL: begin
        busy     = 1'b1;
        bus_rreq = 1'b1;
        cur_word = beat_reg;
        bus_addr = {tag_reg, set_reg, beat_reg, 2'b00};
        if (beat_fire) begin
          fill_en = 1'b1;
          if (beat_reg == '1) begin
            install_en = 1'b1;
            state_next = XFER;
          end
        end
      end
      XFER: begin
        ack = 1'b1;
        if (write_reg) wr_word_en = 1'b1;
        else           rdata      = rd_arr[way_reg];
        if (left_reg == 5'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      tag_reg   <= '0;
      set_reg   <= '0;
      word_reg  <= '0;
      beat_reg  <= '0;
      way_reg   <= '0;
      left_reg  <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (rreq || wreq) begin
            tag_reg   <= TAG_BITS'(tag_of(addr, SET_BITS, WORD_BITS));
            set_reg   <= SET_BITS'(set_of(addr, SET_BITS, WORD_BITS));
            word_reg  <= WORD_BITS'(word_of(addr, WORD_BITS));
            write_reg <= !rreq;
            left_reg  <= (burst_size == 5'd0) ? 5'd1 : burst_size;
          end
        end
        LOOKUP: begin
          way_reg  <= hit_any ? hit_idx : victim_idx;
          beat_reg <= '0;
        end
        WB, FILL: begin
          if (beat_fire) beat_reg <= beat_reg + 1'b1;
        end
        XFER: begin
          word_reg <= word_reg + 1'b1;
          left_reg <= left_reg - 5'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef L2_CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (state_reg == LOOKUP) begin
      if (hit_any) begin
        if (stat_hit != 32'hFFFF_FFFF) stat_hit <= stat_hit + 32'd1;
      end else begin
        if (stat_miss != 32'hFFFF_FFFF) stat_miss <= stat_miss + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Scoreboard bench for l2_cache_assoc: directed requests push expected acks and bus beats,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_l2_cache_assoc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rreq = 1'b0, wreq = 1'b0;
  logic [31:0] addr = '0;
  logic [4:0]  burst_size = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, busy, bus_rreq, bus_wreq;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_acc = 1'b1;
  logic        bus_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int wb_seen = 0;

  typedef struct packed { logic is_read; logic [31:0] data; } ack_exp_t;
  ack_exp_t    ack_q [$];
  logic [31:0] fill_q[$];
  logic [63:0] wb_q  [$];

  always #5 clk = ~clk;

  // Backing memory contents: every word reads as its own address tagged with 0xA in the top nibble.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  assign bus_rdata = mem_val(bus_addr);

  l2_cache_assoc #(.SETS(32), .WAYS(2), .LINE_WORDS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rreq       (rreq),
    .wreq       (wreq),
    .addr       (addr),
    .burst_size (burst_size),
    .wdata      (wdata),
    .rdata      (rdata),
    .ack        (ack),
    .busy       (busy),
    .bus_rreq   (bus_rreq),
    .bus_wreq   (bus_wreq),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_acc    (bus_acc),
    .bus_busy   (bus_busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ack) begin
        if (ack_q.size() == 0) flag("unexpected_ack");
        else begin
          ack_exp_t e;
          e = ack_q.pop_front();
          if (e.is_read) check("ack_rdata", rdata, e.data);
        end
      end
      if (bus_rreq && bus_wreq) flag("bus_rreq_and_wreq");
      if (bus_rreq && bus_acc && !bus_busy) begin
        if (fill_q.size() == 0) flag("unexpected_fill_beat");
        else check("fill_addr", bus_addr, fill_q.pop_front());
      end
      if (bus_wreq && bus_acc && !bus_busy) begin
        wb_seen++;
        if (wb_q.size() == 0) flag("unexpected_wb_beat");
        else begin
          logic [63:0] w;
          w = wb_q.pop_front();
          check("wb_addr", bus_addr, w[63:32]);
          check("wb_data", bus_wdata, w[31:0]);
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [4:0] bs,
                        input logic [31:0] wd, input int exp_lat);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    rreq = !wr; wreq = wr; addr = a; burst_size = bs; wdata = wd;
    while (!got && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack) got = 1'b1;
    end
    rreq = 1'b0;
    wreq = 1'b0;
    if (!got) flag("ack_timeout");
    else check("latency", lat, exp_lat);
    for (int i = 0; i < 40 && ack; i++) begin
      @(posedge clk);
      #1;
    end
    $display("req %s addr=%h burst=%0d latency=%0d", wr ? "WR" : "RD", a, bs, lat);
  endtask

  task automatic push_fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) fill_q.push_back(base + 32'(4 * i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bus_rreq", {31'd0, bus_rreq}, 32'd0);
    check("rst_bus_wreq", {31'd0, bus_wreq}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cold read: 16-beat fill then words 0..3.
    push_fill(32'h0000_1040);
    for (int i = 0; i < 4; i++) ack_q.push_back('{1'b1, 32'hA000_1040 + 32'(4 * i)});
    do_req(1'b0, 32'h0000_1040, 5'd4, 32'd0, 18);

    // Hit write then hit read.
    ack_q.push_back('{1'b0, 32'd0});
    do_req(1'b1, 32'h0000_1044, 5'd1, 32'hDEAD_BEEF, 2);
    ack_q.push_back('{1'b1, 32'hDEAD_BEEF});
    do_req(1'b0, 32'h0000_1044, 5'd1, 32'd0, 2);

    // Wrap within the line: words 15, 0, 1.
    ack_q.push_back('{1'b1, 32'hA000_107C});
    ack_q.push_back('{1'b1, 32'hA000_1040});
    ack_q.push_back('{1'b1, 32'hDEAD_BEEF});
    do_req(1'b0, 32'h0000_107C, 5'd3, 32'd0, 2);

    // Clean miss into way 1 with a 5-cycle bus stall after beat 4.
    push_fill(32'h0000_2040);
    ack_q.push_back('{1'b0, 32'd0});
    fork
      do_req(1'b1, 32'h0000_2040, 5'd1, 32'h2222_0000, 23);
      begin
        @(negedge clk);
        repeat (6) @(posedge clk);
        #2 bus_busy = 1'b1;
        repeat (5) begin
          @(posedge clk);
          #1;
          check("stall_rreq_held", {31'd0, bus_rreq}, 32'd1);
          check("stall_beat_frozen", bus_addr, 32'h0000_2050);
        end
        #1 bus_busy = 1'b0;
      end
    join

    // Eviction: 0x1040 is LRU and dirty -> writeback then fill of 0x3040.
    for (int i = 0; i < 16; i++)
      wb_q.push_back({32'h0000_1040 + 32'(4 * i),
                      (i == 1) ? 32'hDEAD_BEEF : 32'hA000_1040 + 32'(4 * i)});
    push_fill(32'h0000_3040);
    ack_q.push_back('{1'b0, 32'd0});
    do_req(1'b1, 32'h0000_3040, 5'd1, 32'h3333_0000, 34);

    // Reset during writeback of the dirty 0x2040 line.
    for (int i = 0; i < 16; i++)
      wb_q.push_back({32'h0000_2040 + 32'(4 * i),
                      (i == 0) ? 32'h2222_0000 : 32'hA000_2040 + 32'(4 * i)});
    wb_seen = 0;
    @(negedge clk);
    rreq = 1'b1; addr = 32'h0000_1040; burst_size = 5'd1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (wb_seen == 7) break;
    end
    check("wb_beats_before_reset", wb_seen, 32'd7);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wb_bus_wreq", {31'd0, bus_wreq}, 32'd0);
    check("rst_mid_wb_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_wb_ack", {31'd0, ack}, 32'd0);
    $display("req RD addr=00001040 aborted by reset after %0d writeback beats", wb_seen);
    rreq = 1'b0;
    wb_q.delete();
    fill_q.delete();
    ack_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Dirty data was lost: the line misses and refills from memory.
    push_fill(32'h0000_2040);
    ack_q.push_back('{1'b1, 32'hA000_2040});
    do_req(1'b0, 32'h0000_2040, 5'd1, 32'd0, 18);

    repeat (2) @(posedge clk);
    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    check("fill_queue_drained", 32'(fill_q.size()), 32'd0);
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
